// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// gf180mcu_ocd_io__pwr_seq
//   Power-up / power-down sequencer for the gf180mcu_ocd_io pad ring.
//   Synchronises the DVDD/VDD supply-good flags, debounces them, then
//   releases isolation, enables pad drivers and releases core reset in
//   order. Shutdown (FORCE_OFF) walks the same steps in reverse. Loss of
//   either supply from any active state returns to OFF on the next edge.
//
// Ports
//   CLK        always-on sequencer clock
//   RST        asynchronous reset, active-high
//   DVDD_OK    I/O supply good (asynchronous to CLK)
//   VDD_OK     core supply good (asynchronous to CLK)
//   FORCE_OFF  orderly shutdown request; held high keeps the block in OFF
//   ISO_EN     pad isolation clamp, 1 = isolated
//   IO_EN      pad driver enable
//   CORE_RSTN  core reset, active-low
//   PWR_GOOD   high only in RUN
//   STATE      current state encoding
//   FAULT_CNT  saturating count of supply-fault shutdowns
//              (present only when PWRSEQ_FAULT_CNT_EN is defined)
//
// Optional build macro: PWRSEQ_FAULT_CNT_EN

module gf180mcu_ocd_io__pwr_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP_CYCLES     = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DVDD_OK,
    input  logic       VDD_OK,
    input  logic       FORCE_OFF,
    output logic       ISO_EN,
    output logic       IO_EN,
    output logic       CORE_RSTN,
    output logic       PWR_GOOD,
    output logic [2:0] STATE
`ifdef PWRSEQ_FAULT_CNT_EN
    ,
    output logic [7:0] FAULT_CNT
`endif
);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        DEBOUNCE  = 3'd1,
        ISO_REL   = 3'd2,
        IO_ON     = 3'd3,
        RUN       = 3'd4,
        SHDN_CORE = 3'd5,
        SHDN_IO   = 3'd6
    } state_t;

    // Counter holds (dwell - 1) on the last cycle of a state.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [1:0]       dvdd_sync;
    logic [1:0]       vdd_sync;
    logic             sok;
    logic             fault;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       outs_nxt;

    // Two-flop synchronisers for the asynchronous supply flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dvdd_sync <= '0;
            vdd_sync  <= '0;
        end else begin
            dvdd_sync <= {dvdd_sync[0], DVDD_OK};
            vdd_sync  <= {vdd_sync[0], VDD_OK};
        end
    end

    assign sok   = dvdd_sync[1] & vdd_sync[1];
    assign fault = (state != OFF) && !sok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Fault beats FORCE_OFF, which beats dwell expiry.
    always_comb begin
        state_nxt = state;
        if (fault) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF:       if (sok && !FORCE_OFF) state_nxt = DEBOUNCE;
                DEBOUNCE:  if (FORCE_OFF) state_nxt = OFF;
                           else if (cnt == DEB_LAST) state_nxt = ISO_REL;
                ISO_REL:   if (FORCE_OFF) state_nxt = OFF;
                           else if (cnt == STEP_LAST) state_nxt = IO_ON;
                IO_ON:     if (FORCE_OFF) state_nxt = SHDN_IO;
                           else if (cnt == STEP_LAST) state_nxt = RUN;
                RUN:       if (FORCE_OFF) state_nxt = SHDN_CORE;
                SHDN_CORE: if (cnt == STEP_LAST) state_nxt = SHDN_IO;
                SHDN_IO:   if (cnt == STEP_LAST) state_nxt = OFF;
                default:   state_nxt = OFF;
            endcase
        end
    end

    // Counter runs only in timed states and clears on every state change.
    always_comb begin
        cnt_nxt = '0;
        if (state_nxt == state) begin
            case (state)
                DEBOUNCE, ISO_REL, IO_ON, SHDN_CORE, SHDN_IO:
                    cnt_nxt = cnt + CNT_W'(1);
                default:
                    cnt_nxt = '0;
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs change
    // on the same edge as the state register: {ISO, IO, CRN, PG}.
    always_comb begin
        outs_nxt = 4'b1000;
        case (state_nxt)
            ISO_REL:   outs_nxt = 4'b0000;
            IO_ON:     outs_nxt = 4'b0100;
            RUN:       outs_nxt = 4'b0111;
            SHDN_CORE: outs_nxt = 4'b0100;
            SHDN_IO:   outs_nxt = 4'b0000;
            default:   outs_nxt = 4'b1000;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ISO_EN    <= 1'b1;
            IO_EN     <= 1'b0;
            CORE_RSTN <= 1'b0;
            PWR_GOOD  <= 1'b0;
        end else begin
            {ISO_EN, IO_EN, CORE_RSTN, PWR_GOOD} <= outs_nxt;
        end
    end

    assign STATE = state;

`ifdef PWRSEQ_FAULT_CNT_EN
    logic [7:0] fault_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fault_cnt <= '0;
        end else if (fault && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 8'd1;
        end
    end

    assign FAULT_CNT = fault_cnt;
`endif

endmodule

// File: tb/tb_gf180mcu_ocd_io__pwr_seq.sv
module tb_gf180mcu_ocd_io__pwr_seq;

    logic       CLK;
    logic       RST;
    logic       DVDD_OK;
    logic       VDD_OK;
    logic       FORCE_OFF;
    logic       ISO_EN;
    logic       IO_EN;
    logic       CORE_RSTN;
    logic       PWR_GOOD;
    logic [2:0] STATE;
`ifdef PWRSEQ_FAULT_CNT_EN
    logic [7:0] FAULT_CNT;
`endif

    int checks;
    int failures;

    gf180mcu_ocd_io__pwr_seq #(
        .DEBOUNCE_CYCLES(16),
        .STEP_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .DVDD_OK(DVDD_OK),
        .VDD_OK(VDD_OK),
        .FORCE_OFF(FORCE_OFF),
        .ISO_EN(ISO_EN),
        .IO_EN(IO_EN),
        .CORE_RSTN(CORE_RSTN),
        .PWR_GOOD(PWR_GOOD),
        .STATE(STATE)
`ifdef PWRSEQ_FAULT_CNT_EN
        ,
        .FAULT_CNT(FAULT_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output table {ISO, IO, CRN, PG} per state.
    function automatic logic [3:0] exp_out(input logic [2:0] s);
        case (s)
            3'd2:    return 4'b0000;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b0100;
            3'd6:    return 4'b0000;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [3:0] outs();
        return {ISO_EN, IO_EN, CORE_RSTN, PWR_GOOD};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Edge 1 is the first posedge after this returns.
    task automatic do_reset(input logic dv, input logic vd);
        RST       = 1'b1;
        DVDD_OK   = 1'b0;
        VDD_OK    = 1'b0;
        FORCE_OFF = 1'b0;
        repeat (2) @(negedge CLK);
        RST     = 1'b0;
        DVDD_OK = dv;
        VDD_OK  = vd;
    endtask

    task automatic test_reset();
        RST = 1'b1; DVDD_OK = 1'b0; VDD_OK = 1'b0; FORCE_OFF = 1'b0;
        repeat (2) tick();
        checks++;
        if (STATE !== 3'd0 || outs() !== 4'b1000) begin
            failures++;
            $display("FAIL reset_hold state=%0d outs=%b expected state=0 outs=1000", STATE, outs());
        end
`ifdef PWRSEQ_FAULT_CNT_EN
        checks++;
        if (FAULT_CNT !== 8'd0) begin
            failures++;
            $display("FAIL reset_fault_cnt got=%0d expected=0", FAULT_CNT);
        end
`endif
        do_reset(1'b0, 1'b1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (STATE !== 3'd0 || outs() !== 4'b1000) begin
                failures++;
                $display("FAIL reset_no_dvdd edge=%0d state=%0d outs=%b expected state=0 outs=1000", e, STATE, outs());
            end
        end
    endtask

    task automatic test_power_up();
        logic [2:0] es;
        do_reset(1'b1, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            tick();
            es = (e < 3) ? 3'd0 : (e < 19) ? 3'd1 : (e < 27) ? 3'd2 : (e < 35) ? 3'd3 : 3'd4;
            checks++;
            if (STATE !== es || outs() !== exp_out(es)) begin
                failures++;
                $display("FAIL power_up edge=%0d state=%0d outs=%b expected state=%0d outs=%b", e, STATE, outs(), es, exp_out(es));
            end
        end
    endtask

    task automatic test_fault_run();
        logic [2:0] es;
        do_reset(1'b1, 1'b1);
        repeat (35) tick();
        VDD_OK = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            es = (j < 3) ? 3'd4 : 3'd0;
            checks++;
            if (STATE !== es || outs() !== exp_out(es)) begin
                failures++;
                $display("FAIL fault_run step=%0d state=%0d outs=%b expected state=%0d outs=%b", j, STATE, outs(), es, exp_out(es));
            end
        end
`ifdef PWRSEQ_FAULT_CNT_EN
        checks++;
        if (FAULT_CNT !== 8'd1) begin
            failures++;
            $display("FAIL fault_run_cnt got=%0d expected=1", FAULT_CNT);
        end
`endif
        VDD_OK = 1'b1;
    endtask

    task automatic test_force_off_run();
        logic [2:0] es;
        do_reset(1'b1, 1'b1);
        repeat (35) tick();
        FORCE_OFF = 1'b1;
        tick();
        FORCE_OFF = 1'b0;
        checks++;
        if (STATE !== 3'd5 || outs() !== 4'b0100) begin
            failures++;
            $display("FAIL force_off_edge_n state=%0d outs=%b expected state=5 outs=0100", STATE, outs());
        end
        for (int j = 1; j <= 33; j++) begin
            tick();
            es = (j < 8) ? 3'd5 : (j < 16) ? 3'd6 : (j == 16) ? 3'd0 : (j < 33) ? 3'd1 : 3'd2;
            checks++;
            if (STATE !== es || outs() !== exp_out(es)) begin
                failures++;
                $display("FAIL force_off_seq n+%0d state=%0d outs=%b expected state=%0d outs=%b", j, STATE, outs(), es, exp_out(es));
            end
        end
`ifdef PWRSEQ_FAULT_CNT_EN
        checks++;
        if (FAULT_CNT !== 8'd0) begin
            failures++;
            $display("FAIL force_off_no_count got=%0d expected=0", FAULT_CNT);
        end
`endif
    endtask

    task automatic test_force_early();
        // FORCE_OFF held from the start keeps the block in OFF.
        do_reset(1'b1, 1'b1);
        FORCE_OFF = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (STATE !== 3'd0) begin
                failures++;
                $display("FAIL force_hold_off edge=%0d state=%0d expected=0", e, STATE);
            end
        end
        FORCE_OFF = 1'b0;
        tick();
        checks++;
        if (STATE !== 3'd1) begin
            failures++;
            $display("FAIL force_release state=%0d expected=1", STATE);
        end
        repeat (4) tick();
        FORCE_OFF = 1'b1;
        tick();
        FORCE_OFF = 1'b0;
        checks++;
        if (STATE !== 3'd0 || outs() !== 4'b1000) begin
            failures++;
            $display("FAIL force_in_debounce state=%0d outs=%b expected state=0 outs=1000", STATE, outs());
        end
        // ISO_REL -> OFF
        do_reset(1'b1, 1'b1);
        repeat (20) tick();
        FORCE_OFF = 1'b1;
        tick();
        FORCE_OFF = 1'b0;
        checks++;
        if (STATE !== 3'd0 || outs() !== 4'b1000) begin
            failures++;
            $display("FAIL force_in_iso_rel state=%0d outs=%b expected state=0 outs=1000", STATE, outs());
        end
        // IO_ON -> SHDN_IO -> OFF after 8 cycles
        do_reset(1'b1, 1'b1);
        repeat (28) tick();
        FORCE_OFF = 1'b1;
        tick();
        FORCE_OFF = 1'b0;
        checks++;
        if (STATE !== 3'd6 || outs() !== 4'b0000) begin
            failures++;
            $display("FAIL force_in_io_on state=%0d outs=%b expected state=6 outs=0000", STATE, outs());
        end
        repeat (7) tick();
        checks++;
        if (STATE !== 3'd6) begin
            failures++;
            $display("FAIL shdn_io_dwell state=%0d expected=6", STATE);
        end
        tick();
        checks++;
        if (STATE !== 3'd0 || outs() !== 4'b1000) begin
            failures++;
            $display("FAIL shdn_io_exit state=%0d outs=%b expected state=0 outs=1000", STATE, outs());
        end
    endtask

    task automatic test_glitch();
        logic [2:0] es;
        do_reset(1'b1, 1'b1);
        repeat (13) tick();
        DVDD_OK = 1'b0;
        tick();
        DVDD_OK = 1'b1;
        for (int e = 15; e <= 34; e++) begin
            tick();
            es = (e == 15) ? 3'd1 : (e == 16) ? 3'd0 : (e < 33) ? 3'd1 : 3'd2;
            checks++;
            if (STATE !== es || outs() !== exp_out(es)) begin
                failures++;
                $display("FAIL glitch edge=%0d state=%0d outs=%b expected state=%0d outs=%b", e, STATE, outs(), es, exp_out(es));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1'b1);
        repeat (30) tick();
        checks++;
        if (STATE !== 3'd3) begin
            failures++;
            $display("FAIL reset_mid_pre state=%0d expected=3", STATE);
        end
        RST = 1'b1;
        #2;
        checks++;
        if (STATE !== 3'd0 || outs() !== 4'b1000) begin
            failures++;
            $display("FAIL reset_mid_async state=%0d outs=%b expected state=0 outs=1000", STATE, outs());
        end
        tick();
        RST = 1'b0;
    endtask

`ifdef PWRSEQ_FAULT_CNT_EN
    task automatic test_fault_sat();
        do_reset(1'b1, 1'b1);
        repeat (3) tick();
        for (int f = 1; f <= 300; f++) begin
            DVDD_OK = 1'b0;
            tick();
            DVDD_OK = 1'b1;
            repeat (3) tick();
            if (f == 1 || f == 255 || f == 300) begin
                checks++;
                if (FAULT_CNT !== ((f > 255) ? 8'd255 : 8'(f))) begin
                    failures++;
                    $display("FAIL fault_sat after=%0d got=%0d expected=%0d", f, FAULT_CNT, (f > 255) ? 255 : f);
                end
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_power_up();
        test_fault_run();
        test_force_off_run();
        test_force_early();
        test_glitch();
        test_reset_mid();
`ifdef PWRSEQ_FAULT_CNT_EN
        test_fault_sat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
